// File: rtl/fp_sqrt_seq_pkg.sv
// Shared FPU definitions: rounding-mode codes, operand classes, FSM states.
// Imported by the fp_sqrt_seq top and its recurrence core.
package fp_sqrt_seq_pkg;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RZ  = 3'd1;
  localparam logic [2:0] RM_RD  = 3'd2;
  localparam logic [2:0] RM_RU  = 3'd3;
  localparam logic [2:0] RM_RNA = 3'd4;

  typedef enum logic [2:0] {
    C_ZERO,
    C_SUB,
    C_NORM,
    C_INF,
    C_QNAN,
    C_SNAN
  } fp_class_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_RND
  } sqrt_state_t;

endpackage

// File: rtl/fp_sqrt_core.sv
// Radix-2 restoring square-root recurrence, one root bit per step.
// Produces fraction+guard bits of the root and a sticky flag.
module fp_sqrt_core
  import fp_sqrt_seq_pkg::*;
#(
  parameter int MW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [MW+1:0] mant,
  output logic [MW:0]   res,
  output logic          sticky
);

  logic [2*MW+3:0] rad;
  logic [MW+3:0]   rem;
  logic [MW+1:0]   root;
  logic [MW+5:0]   trial_rem;
  logic [MW+5:0]   trial;
  logic            ge;
  logic [MW+3:0]   rem_n;

  // Trial subtraction of (4*root + 1) from the shifted-in partial remainder
  always_comb begin
    trial_rem = {rem, rad[2*MW+3 -: 2]};
    trial     = {2'b00, root, 2'b01};
    ge        = (trial_rem >= trial);
    rem_n     = ge ? (MW+4)'(trial_rem - trial)
                   : (MW+4)'(trial_rem);
  end

  // Recurrence state: radicand shifter, remainder, developing root
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rad  <= '0;
      rem  <= '0;
      root <= '0;
    end else if (load) begin
      rad  <= {mant, {(MW+2){1'b0}}};
      rem  <= '0;
      root <= '0;
    end else if (step) begin
      rad  <= rad << 2;
      rem  <= rem_n;
      root <= {root[MW:0], ge};
    end
  end

  assign res    = root[MW:0];
  assign sticky = |rem;

endmodule

// File: rtl/fp_sqrt_seq.sv
// Sequential IEEE-754 square root with act/busy/done handshake.
// FP_SQRT_SUBNORM_EN: normalise subnormal inputs instead of flushing them.
module fp_sqrt_seq
  import fp_sqrt_seq_pkg::*;
#(
  parameter  int EW   = 8,
  parameter  int MW   = 23,
  localparam int W    = EW + MW + 1,
  localparam int BIAS = 2**(EW-1) - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [2:0]   round_m,
  output logic [W-1:0] out,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         inexact,
  output logic         done,
  output logic         busy
);

  localparam int XW = EW + 2;
  localparam int CW = $clog2(MW + 2);
  localparam logic [CW-1:0] LAST = CW'(MW + 1);
  localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic [W-1:0] QNAN =
    {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
  localparam logic [W-1:0] PINF =
    {1'b0, {EW{1'b1}}, {MW{1'b0}}};

  sqrt_state_t state, state_n;

  logic [W-1:0]  op_q;
  logic [2:0]    rm_q;
  logic [CW-1:0] cnt;
  logic [EW-1:0] res_exp;
  logic          spec_q;
  logic [W-1:0]  spec_out_q;
  logic          spec_inv_q;

  logic          sgn;
  logic [EW-1:0] bexp;
  logic [MW-1:0] frac;
  fp_class_t     cls;

  logic                 is_spec;
  logic [W-1:0]         spec_out;
  logic                 spec_inv;
  logic [MW+1:0]        mant;
  logic [MW+1:0]        mant_s;
  logic signed [XW-1:0] e_unb;
  logic signed [XW-1:0] e_even;
  logic [EW-1:0]        exp_r;

  logic [MW:0]    root_f;
  logic           sticky;
  logic           g;
  logic           incr;
  logic [W-2:0]   rnd_sum;

  assign {sgn, bexp, frac} = op_q;
  assign ov = 1'b0;
  assign un = 1'b0;

  // Operand class decode
  always_comb begin
    cls = C_NORM;
    if (bexp == '0)
      cls = (frac == '0) ? C_ZERO : C_SUB;
    else if (&bexp)
      cls = (frac == '0) ? C_INF
          : (frac[MW-1] ? C_QNAN : C_SNAN);
  end

  // Special-value result selection
  always_comb begin
    is_spec  = 1'b1;
    spec_out = QNAN;
    spec_inv = 1'b0;
    if (cls == C_QNAN) begin
      spec_inv = 1'b0;
    end else if (cls == C_SNAN) begin
      spec_inv = 1'b1;
`ifdef FP_SQRT_SUBNORM_EN
    end else if (cls == C_ZERO) begin
`else
    end else if (cls == C_ZERO || cls == C_SUB) begin
`endif
      spec_out = {sgn, {(W-1){1'b0}}};
    end else if (sgn) begin
      spec_inv = 1'b1;
    end else if (cls == C_INF) begin
      spec_out = PINF;
    end else begin
      is_spec = 1'b0;
    end
  end

  // Mantissa normalisation and even-exponent adjustment
  always_comb begin
    mant  = {2'b01, frac};
    e_unb = $signed({2'b00, bexp}) - BIAS_X;
`ifdef FP_SQRT_SUBNORM_EN
    if (cls == C_SUB) begin
      int lz;
      lz = 0;
      for (int i = 0; i < MW; i++)
        if (frac[i]) lz = MW - 1 - i;
      mant  = (MW+2)'({2'b00, frac} << (lz + 1));
      e_unb = -BIAS_X - XW'(lz);
    end
`endif
    mant_s = mant;
    e_even = e_unb;
    if (e_unb[0]) begin
      mant_s = mant << 1;
      e_even = e_unb - ONE_X;
    end
    exp_r = EW'((e_even >>> 1) + BIAS_X);
  end

  fp_sqrt_core #(.MW(MW)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (state == S_PREP),
    .step   (state == S_CALC),
    .mant   (mant_s),
    .res    (root_f),
    .sticky (sticky)
  );

  // Rounding increment; the root is always positive so RD truncates
  always_comb begin
    g = root_f[0];
    unique case (rm_q)
      RM_RZ:   incr = 1'b0;
      RM_RD:   incr = 1'b0;
      RM_RU:   incr = g | sticky;
      RM_RNA:  incr = g;
      default: incr = g & (sticky | root_f[1]);
    endcase
    rnd_sum = {res_exp, root_f[MW:1]} + (W-1)'(incr);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (act) state_n = S_PREP;
      S_PREP:  state_n = is_spec ? S_RND : S_CALC;
      S_CALC:  if (cnt == LAST) state_n = S_RND;
      S_RND:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operand capture, prep results, iteration count and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= '0;
      rm_q       <= '0;
      cnt        <= '0;
      res_exp    <= '0;
      spec_q     <= 1'b0;
      spec_out_q <= '0;
      spec_inv_q <= 1'b0;
      out        <= '0;
      inv        <= 1'b0;
      inexact    <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (act) begin
            op_q <= in1;
            rm_q <= round_m;
            busy <= 1'b1;
          end
        end
        S_PREP: begin
          spec_q     <= is_spec;
          spec_out_q <= spec_out;
          spec_inv_q <= spec_inv;
          res_exp    <= exp_r;
          cnt        <= '0;
        end
        S_CALC: cnt <= cnt + 1'b1;
        S_RND: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (spec_q) begin
            out     <= spec_out_q;
            inv     <= spec_inv_q;
            inexact <= 1'b0;
          end else begin
            out     <= {1'b0, rnd_sum};
            inv     <= 1'b0;
            inexact <= g | sticky;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
